softmax_sched: RTL and testbench

- Round-robin scheduler that shares one softmax engine among NUM_REQ requesters (parallel classifier heads / batch lanes).
- Latches the winning requester's 10-value vector and drives the engine's enable-level handshake. Waits for the engine's done flag, returns the normalized vector with the requester ID, then forces the engine back to idle before the next job.
- Sits between the CNN output stage and the softmax engine.

---
 rtl/softmax_sched_if.sv | 37 +++
 rtl/softmax_sched.sv | 150 +++++++++++++++
 tb/tb_softmax_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_sched_if.sv
// Requester, engine and result signal bundle for softmax_sched.
// The scheduler takes the master modport and its environment takes the slave modport.
interface softmax_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INPUT_NUM  = 10,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
);
  localparam int VEC_W = DATA_WIDTH * INPUT_NUM;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*VEC_W-1:0] req_inputs;
  logic [NUM_REQ-1:0]       gnt;
  logic [VEC_W-1:0]         sm_inputs;
  logic                     sm_enable;
  logic [VEC_W-1:0]         sm_outputs;
  logic                     sm_ack;
  logic [VEC_W-1:0]         res_data;
  logic [ID_W-1:0]          res_id;
  logic                     res_valid;
  logic                     res_err;
  logic                     res_ready;
  logic                     busy;
  logic [15:0]              job_cnt;

  modport master (
    input  req, req_inputs, sm_outputs, sm_ack, res_ready,
    output gnt, sm_inputs, sm_enable, res_data, res_id, res_valid, res_err,
           busy, job_cnt
  );

  modport slave (
    output req, req_inputs, sm_outputs, sm_ack, res_ready,
    input  gnt, sm_inputs, sm_enable, res_data, res_id, res_valid, res_err,
           busy, job_cnt
  );
endinterface

// File: rtl/softmax_sched.sv
// Round-robin scheduler sharing one softmax engine among NUM_REQ requesters.
// Define SOFTMAX_SCHED_TIMEOUT_EN to enable the RUN-state watchdog (TIMEOUT_CYCLES).
module softmax_sched #(
  parameter int DATA_WIDTH     = 32,
  parameter int INPUT_NUM      = 10,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               reset,
  softmax_sched_if.master   bus
);
  localparam int VEC_W = DATA_WIDTH * INPUT_NUM;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] RESULT  = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  if ((1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gParamCheck
    $error("softmax_sched: ID_W too narrow for NUM_REQ or TIMEOUT_CYCLES out of 16-bit range");
  end

  logic [1:0]             state;
  logic [ID_W-1:0]        rrPtr;
  logic [ID_W-1:0]        winner;
  logic                   anyReq;
  logic [ID_W:0]          scanPos;
  logic [2*NUM_REQ-1:0]   reqDbl;
  logic [NUM_REQ-1:0]     gntQ;
  logic [VEC_W-1:0]       smInputsQ;
  logic                   smEnableQ;
  logic [VEC_W-1:0]       resDataQ;
  logic [ID_W-1:0]        resIdQ;
  logic                   resValidQ;
  logic [15:0]            jobCnt;

  assign reqDbl = {bus.req, bus.req};

  // Scan downward so the set bit closest after rrPtr is the last one assigned.
  always_comb begin
    winner  = rrPtr;
    anyReq  = 1'b0;
    scanPos = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scanPos = {1'b0, rrPtr} + (ID_W+1)'(k);
      if (reqDbl[scanPos]) begin
        anyReq = 1'b1;
        winner = (scanPos >= (ID_W+1)'(NUM_REQ)) ? ID_W'(scanPos - (ID_W+1)'(NUM_REQ))
                                                 : ID_W'(scanPos);
      end
    end
  end

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
  logic [15:0] toCnt;
  logic        timedOut;
  logic        resErrQ;

  // Cleared while idle, so every RUN entry starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      toCnt <= '0;
    end else if (state == RUN) begin
      toCnt <= toCnt + 16'd1;
    end else begin
      toCnt <= '0;
    end
  end

  assign timedOut    = (state == RUN) && (toCnt == 16'(TIMEOUT_CYCLES - 1));
  assign bus.res_err = resErrQ;
`else
  assign bus.res_err = 1'b0;
`endif

  // Job sequencing: grant and latch, run, hold result, then keep the engine in reset a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rrPtr     <= ID_W'(NUM_REQ - 1);
      gntQ      <= '0;
      smInputsQ <= '0;
      smEnableQ <= 1'b0;
      resDataQ  <= '0;
      resIdQ    <= '0;
      resValidQ <= 1'b0;
      jobCnt    <= '0;
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
      resErrQ   <= 1'b0;
`endif
    end else begin
      gntQ <= '0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            gntQ      <= NUM_REQ'(1) << winner;
            smInputsQ <= bus.req_inputs[int'(winner)*VEC_W +: VEC_W];
            resIdQ    <= winner;
            rrPtr     <= winner;
            smEnableQ <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (bus.sm_ack) begin
            resDataQ  <= bus.sm_outputs;
            resValidQ <= 1'b1;
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
            resErrQ   <= 1'b0;
`endif
            state     <= RESULT;
          end
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
          else if (timedOut) begin
            resDataQ  <= '0;
            resValidQ <= 1'b1;
            resErrQ   <= 1'b1;
            state     <= RESULT;
          end
`endif
        end
        RESULT: begin
          if (bus.res_ready) begin
            resValidQ <= 1'b0;
            smEnableQ <= 1'b0;
            jobCnt    <= jobCnt + 16'd1;
            state     <= RECOVER;
          end
        end
        RECOVER: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gntQ;
  assign bus.sm_inputs = smInputsQ;
  assign bus.sm_enable = smEnableQ;
  assign bus.res_data  = resDataQ;
  assign bus.res_id    = resIdQ;
  assign bus.res_valid = resValidQ;
  assign bus.busy      = (state != IDLE);
  assign bus.job_cnt   = jobCnt;
endmodule

// File: tb/tb_softmax_sched.sv
// Testbench for softmax_sched: transaction-level model checked every cycle plus directed scenarios.
// The watchdog scenario only runs when SOFTMAX_SCHED_TIMEOUT_EN is defined.
module tb_softmax_sched;
  localparam int DATA_WIDTH     = 32;
  localparam int INPUT_NUM      = 10;
  localparam int NUM_REQ        = 4;
  localparam int ID_W           = 2;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int VEC_W          = DATA_WIDTH * INPUT_NUM;

  localparam int P_IDLE    = 0;
  localparam int P_RUN     = 1;
  localparam int P_RESULT  = 2;
  localparam int P_RECOVER = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  softmax_sched_if #(
    .DATA_WIDTH(DATA_WIDTH), .INPUT_NUM(INPUT_NUM), .NUM_REQ(NUM_REQ), .ID_W(ID_W)
  ) ifc ();

  softmax_sched #(
    .DATA_WIDTH(DATA_WIDTH), .INPUT_NUM(INPUT_NUM), .NUM_REQ(NUM_REQ), .ID_W(ID_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  logic [VEC_W-1:0] vecs [NUM_REQ];
  assign ifc.req_inputs = {vecs[3], vecs[2], vecs[1], vecs[0]};

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [VEC_W-1:0] act,
                             input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stand-in engine: all-zero lanes give 0.1f (uniform softmax), other lanes a fixed scramble.
  function automatic logic [VEC_W-1:0] engineFunc(input logic [VEC_W-1:0] v);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < INPUT_NUM; i++)
      r[i*DATA_WIDTH +: DATA_WIDTH] = (v[i*DATA_WIDTH +: DATA_WIDTH] == 32'h0) ?
                                      32'h3DCCCCCD : (v[i*DATA_WIDTH +: DATA_WIDTH] ^ 32'h5A5A5A5A);
    return r;
  endfunction

  logic             engAck      = 1'b0;
  logic [VEC_W-1:0] engOut      = '0;
  int               engCnt      = 0;
  int               engLat      = 40;
  bit               neverAck    = 1'b0;
  logic             spuriousAck = 1'b0;

  assign ifc.sm_ack     = engAck | spuriousAck;
  assign ifc.sm_outputs = engOut;

  always @(posedge clk) begin
    if (ifc.sm_enable !== 1'b1) begin
      engCnt <= 0;
      engAck <= 1'b0;
    end else if (!neverAck && !engAck) begin
      if (engCnt == engLat) begin
        engAck <= 1'b1;
        engOut <= engineFunc(ifc.sm_inputs);
      end else begin
        engCnt <= engCnt + 1;
      end
    end
  end

  function automatic int arbitrate(input int ptr, input logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (((r >> idx) & NUM_REQ'(1)) != 0) return idx;
    end
    return -1;
  endfunction

  logic [NUM_REQ-1:0] expGnt;
  logic [VEC_W-1:0]   expSmIn, expData, mVec;
  logic [ID_W-1:0]    expId;
  logic               expEn, expValid, expErr, expBusy;
  logic [15:0]        expJobs;
  int                 mPhase, mPtr, mRun, mWin;
  bit                 mValid  = 1'b0;
  int                 lowRun  = 0;
  bit                 seenJob = 1'b0;

  // Check what the previous prediction promised, then predict the next edge from current inputs.
  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("gnt", VEC_W'(ifc.gnt), VEC_W'(expGnt));
      checkOutput("smEnable", VEC_W'(ifc.sm_enable), VEC_W'(expEn));
      checkOutput("smInputs", ifc.sm_inputs, expSmIn);
      checkOutput("resValid", VEC_W'(ifc.res_valid), VEC_W'(expValid));
      checkOutput("resId", VEC_W'(ifc.res_id), VEC_W'(expId));
      checkOutput("resErr", VEC_W'(ifc.res_err), VEC_W'(expErr));
      checkOutput("resData", ifc.res_data, expData);
      checkOutput("busy", VEC_W'(ifc.busy), VEC_W'(expBusy));
      checkOutput("jobCnt", VEC_W'(ifc.job_cnt), VEC_W'(expJobs));
      if (ifc.sm_enable === 1'b1) begin
        if (seenJob && lowRun > 0) checkOutput("enGap", VEC_W'(lowRun >= 2), VEC_W'(1));
        lowRun  = 0;
        seenJob = 1'b1;
      end else begin
        lowRun++;
      end
    end
    expGnt = '0;
    if (reset) begin
      mValid  = 1'b1;
      mPhase  = P_IDLE;
      mPtr    = NUM_REQ - 1;
      mRun    = 0;
      mVec    = '0;
      expSmIn = '0;
      expData = '0;
      expId   = '0;
      expEn   = 1'b0;
      expValid = 1'b0;
      expErr  = 1'b0;
      expJobs = '0;
      seenJob = 1'b0;
      lowRun  = 0;
    end else if (mValid) begin
      case (mPhase)
        P_IDLE: begin
          mWin = arbitrate(mPtr, ifc.req);
          if (mWin >= 0) begin
            expGnt  = NUM_REQ'(1) << mWin;
            mVec    = ifc.req_inputs[mWin*VEC_W +: VEC_W];
            expSmIn = mVec;
            expId   = ID_W'(mWin);
            mPtr    = mWin;
            expEn   = 1'b1;
            mRun    = 0;
            mPhase  = P_RUN;
          end
        end
        P_RUN: begin
          if (ifc.sm_ack === 1'b1) begin
            expData  = engineFunc(mVec);
            expValid = 1'b1;
            expErr   = 1'b0;
            mPhase   = P_RESULT;
          end
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
          else begin
            mRun++;
            if (mRun == TIMEOUT_CYCLES) begin
              expData  = '0;
              expValid = 1'b1;
              expErr   = 1'b1;
              mPhase   = P_RESULT;
            end
          end
`endif
        end
        P_RESULT: begin
          if (ifc.res_ready === 1'b1) begin
            expValid = 1'b0;
            expEn    = 1'b0;
            expJobs  = expJobs + 16'd1;
            mPhase   = P_RECOVER;
          end
        end
        default: mPhase = P_IDLE;
      endcase
    end
    expBusy = (mPhase != P_IDLE);
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic rdy);
    @(posedge clk);
    #1;
    ifc.req       = r;
    ifc.res_ready = rdy;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic waitGnt(input int maxCyc, output logic [NUM_REQ-1:0] g);
    g = '0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (ifc.gnt != '0) begin
        g = ifc.gnt;
        return;
      end
    end
    checkOutput("gntTimeout", VEC_W'(1), VEC_W'(0));
  endtask

  task automatic waitValid(input int maxCyc);
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (ifc.res_valid === 1'b1) return;
    end
    checkOutput("validTimeout", VEC_W'(1), VEC_W'(0));
  endtask

  task automatic waitJobs(input int target, input int maxCyc);
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (ifc.job_cnt == 16'(target)) return;
    end
    checkOutput("jobTimeout", VEC_W'(1), VEC_W'(0));
  endtask

  function automatic int oneHotIdx(input logic [NUM_REQ-1:0] g);
    for (int i = 0; i < NUM_REQ; i++)
      if (((g >> i) & NUM_REQ'(1)) != 0) return i;
    return -1;
  endfunction

  logic [NUM_REQ-1:0] g;
  int expOrder [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int toN;

  initial begin
    ifc.req       = '0;
    ifc.res_ready = 1'b0;
    vecs[0] = '0;
    for (int k = 1; k < NUM_REQ; k++)
      for (int i = 0; i < INPUT_NUM; i++)
        vecs[k][i*DATA_WIDTH +: DATA_WIDTH] = 32'h3F800000 + 32'(k*256 + i);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] single job, zero vector");
    engLat = 40;
    applyStimulus(4'b0001, 1'b0);
    waitGnt(20, g);
    checkOutput("t1Gnt", VEC_W'(g), VEC_W'(4'b0001));
    @(negedge clk);
    checkOutput("t1GntPulse", VEC_W'(ifc.gnt), VEC_W'(0));
    applyStimulus(4'b0000, 1'b0);
    waitValid(100);
    checkOutput("t1Id", VEC_W'(ifc.res_id), VEC_W'(0));
    checkOutput("t1Data", ifc.res_data, {10{32'h3DCCCCCD}});
    applyStimulus(4'b0000, 1'b1);
    waitJobs(1, 10);
    checkOutput("t1Jobs", VEC_W'(ifc.job_cnt), VEC_W'(1));

    $display("[TB] round robin, all requesting");
    doReset();
    engLat = 5;
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      waitGnt(100, g);
      checkOutput("t2Order", VEC_W'(oneHotIdx(g)), VEC_W'(expOrder[i]));
    end
    applyStimulus(4'b0000, 1'b1);
    waitJobs(8, 100);
    checkOutput("t2Jobs", VEC_W'(ifc.job_cnt), VEC_W'(8));

    $display("[TB] result backpressure");
    engLat = 10;
    applyStimulus(4'b0010, 1'b0);
    waitGnt(20, g);
    checkOutput("t3Gnt", VEC_W'(g), VEC_W'(4'b0010));
    applyStimulus(4'b1001, 1'b0);
    waitValid(50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t3Hold", VEC_W'({ifc.res_valid, ifc.sm_enable, ifc.gnt}), VEC_W'(6'b110000));
    end
    applyStimulus(4'b0000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t3Done", VEC_W'({ifc.res_valid, ifc.job_cnt}), VEC_W'({1'b0, 16'd9}));

    $display("[TB] reset during run");
    engLat = 40;
    applyStimulus(4'b0001, 1'b1);
    waitGnt(20, g);
    applyStimulus(4'b0000, 1'b1);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t4Reset", VEC_W'({ifc.sm_enable, ifc.res_valid, ifc.busy, ifc.job_cnt}),
                VEC_W'({3'b000, 16'd0}));
    engLat = 5;
    applyStimulus(4'b0100, 1'b1);
    waitGnt(20, g);
    checkOutput("t4Gnt", VEC_W'(g), VEC_W'(4'b0100));
    applyStimulus(4'b0000, 1'b1);
    waitJobs(1, 50);

    $display("[TB] spurious engine acks");
    applyStimulus(4'b0000, 1'b1);
    spuriousAck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5IdleAck", VEC_W'({ifc.res_valid, ifc.busy, ifc.job_cnt}),
                  VEC_W'({2'b00, 16'd1}));
    end
    @(posedge clk);
    #1 spuriousAck = 1'b0;
    applyStimulus(4'b0001, 1'b0);
    waitGnt(20, g);
    applyStimulus(4'b0000, 1'b0);
    waitValid(50);
    applyStimulus(4'b0000, 1'b1);
    spuriousAck = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t5RecoverAck", VEC_W'({ifc.res_valid, ifc.job_cnt}), VEC_W'({1'b0, 16'd2}));
    end
    @(posedge clk);
    #1 spuriousAck = 1'b0;

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    neverAck = 1'b1;
    applyStimulus(4'b0001, 1'b1);
    waitGnt(20, g);
    toN = 0;
    while (toN < 200) begin
      @(negedge clk);
      toN++;
      if (ifc.res_valid === 1'b1) break;
    end
    checkOutput("toLatency", VEC_W'(toN), VEC_W'(TIMEOUT_CYCLES));
    checkOutput("toErr", VEC_W'(ifc.res_err), VEC_W'(1));
    checkOutput("toData", ifc.res_data, VEC_W'(0));
    applyStimulus(4'b0000, 1'b1);
    neverAck = 1'b0;
    waitJobs(3, 20);
    checkOutput("toJobs", VEC_W'(ifc.job_cnt), VEC_W'(3));
    applyStimulus(4'b0010, 1'b1);
    waitGnt(20, g);
    applyStimulus(4'b0000, 1'b1);
    waitValid(50);
    checkOutput("toNextErr", VEC_W'(ifc.res_err), VEC_W'(0));
    waitJobs(4, 20);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end
endmodule
